// File: rtl/line_dma_master_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | line_dma_pkg : shared constants, state codes and address builder          |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
package line_dma_pkg;

  localparam int OBID_BASE_BIT = 37;
  localparam int NUM_OBJECT    = 3;
  localparam int ADDR_W        = 40;
  localparam int WORD_W        = 10;
  localparam int LINE_W        = 512;
  localparam int LINE_WORDS    = 16;

  localparam logic [NUM_OBJECT-1:0] OBJ_A = 3'd4;
  localparam logic [NUM_OBJECT-1:0] OBJ_X = 3'd2;
  localparam logic [NUM_OBJECT-1:0] OBJ_Y = 3'd1;

  typedef logic [3:0] state_t;
  localparam state_t ST_IDLE       = 4'd0;
  localparam state_t ST_RD_ISSUE   = 4'd1;
  localparam state_t ST_RD_WAIT    = 4'd2;
  localparam state_t ST_RD_HOLD    = 4'd3;
  localparam state_t ST_WR_FETCH   = 4'd4;
  localparam state_t ST_WR_ISSUE   = 4'd5;
  localparam state_t ST_WR_WAIT_LO = 4'd6;
  localparam state_t ST_WR_WAIT_HI = 4'd7;
  localparam state_t ST_WR_SETTLE  = 4'd8;
  localparam state_t ST_FIN        = 4'd9;

  function automatic logic [ADDR_W-1:0] mk_addr(input logic [NUM_OBJECT-1:0] obj,
                                                input logic [WORD_W-1:0]     word);
    logic [ADDR_W-1:0] a;
    a = '0;
    a[OBID_BASE_BIT +: NUM_OBJECT] = obj;
    a[WORD_W+1:2] = word;
    return a;
  endfunction

endpackage
`default_nettype wire

// File: rtl/line_dma_master_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | line_dma_master_if : line-memory access bus (separate read/write halves)  |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
interface line_dma_master_if;
  import line_dma_pkg::*;

  logic [ADDR_W-1:0] APB_WADDR;
  logic [ADDR_W-1:0] APB_RADDR;
  logic [LINE_W-1:0] APB_WDATA;
  logic              APB_WENABLE;
  logic              APB_RENABLE;
  logic              APB_WREADY;
  logic              APB_RREADY;
  logic              APB_RVALID;
  logic [LINE_W-1:0] APB_RDATA;

  modport master (
    output APB_WADDR, APB_RADDR, APB_WDATA, APB_WENABLE, APB_RENABLE,
    input  APB_WREADY, APB_RREADY, APB_RVALID, APB_RDATA
  );

  modport slave (
    input  APB_WADDR, APB_RADDR, APB_WDATA, APB_WENABLE, APB_RENABLE,
    output APB_WREADY, APB_RREADY, APB_RVALID, APB_RDATA
  );

endinterface
`default_nettype wire

// File: rtl/line_dma_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | line_dma_master : runs one multi-line read/write command on the line bus  |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module line_dma_master
  import line_dma_pkg::*;
#(
  parameter int LEN_W       = 7,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [NUM_OBJECT-1:0] cmd_obj,
  input  logic [WORD_W-1:0]     cmd_word,
  input  logic [LEN_W-1:0]      cmd_lines,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [LINE_W-1:0]     rd_data,
  output logic                  rd_last,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [LINE_W-1:0]     wr_data,
  output logic                  done,
  output logic                  err,
  line_dma_master_if.master     bus
);

  localparam int                WAIT_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WAIT_W-1:0] c_TMO_LAST = WAIT_W'(TIMEOUT_CYC - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [WAIT_W-1:0]       r_wait;
  logic [LEN_W-1:0]        r_remain;
  logic [NUM_OBJECT-1:0]   r_obj;
  logic [WORD_W-1:0]       r_word;
  logic                    r_err;
  logic                    r_rd_valid;
  logic                    r_rd_last;
  logic [LINE_W-1:0]       r_rd_data;
  logic [LINE_W-1:0]       r_wdata;
  logic [ADDR_W-1:0]       r_waddr;
  logic [ADDR_W-1:0]       r_raddr;
  logic                    r_wen;
  logic                    r_ren;

  logic w_accept, w_rd_issue, w_rd_cap, w_rd_take, w_wr_take, w_wr_issue;
  logic w_tmo, w_last, w_step, w_abort;

  assign w_accept   = (r_state == ST_IDLE)     && cmd_valid;
  assign w_rd_issue = (r_state == ST_RD_ISSUE) && bus.APB_RREADY;
  assign w_rd_cap   = (r_state == ST_RD_WAIT)  && bus.APB_RVALID;
  assign w_rd_take  = (r_state == ST_RD_HOLD)  && rd_ready;
  assign w_wr_take  = (r_state == ST_WR_FETCH) && wr_valid;
  assign w_wr_issue = (r_state == ST_WR_ISSUE) && bus.APB_WREADY;
  assign w_tmo      = (r_wait == c_TMO_LAST);
  assign w_last     = (r_remain == LEN_W'(1));
  assign w_step     = w_rd_take || (r_state == ST_WR_SETTLE);
  assign w_abort    = w_tmo && (((r_state == ST_RD_WAIT)    && !bus.APB_RVALID) ||
                                ((r_state == ST_WR_WAIT_LO) &&  bus.APB_WREADY) ||
                                ((r_state == ST_WR_WAIT_HI) && !bus.APB_WREADY));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:       if (cmd_valid)
                       w_state_nxt = (cmd_lines == '0) ? ST_FIN :
                                     (cmd_write ? ST_WR_FETCH : ST_RD_ISSUE);
      ST_RD_ISSUE:   if (bus.APB_RREADY) w_state_nxt = ST_RD_WAIT;
      ST_RD_WAIT:    if (bus.APB_RVALID) w_state_nxt = ST_RD_HOLD;
                     else if (w_tmo)     w_state_nxt = ST_FIN;
      ST_RD_HOLD:    if (rd_ready)       w_state_nxt = w_last ? ST_FIN : ST_RD_ISSUE;
      ST_WR_FETCH:   if (wr_valid)       w_state_nxt = ST_WR_ISSUE;
      ST_WR_ISSUE:   if (bus.APB_WREADY) w_state_nxt = ST_WR_WAIT_LO;
      ST_WR_WAIT_LO: if (!bus.APB_WREADY) w_state_nxt = ST_WR_WAIT_HI;
                     else if (w_tmo)      w_state_nxt = ST_FIN;
      ST_WR_WAIT_HI: if (bus.APB_WREADY) w_state_nxt = ST_WR_SETTLE;
                     else if (w_tmo)     w_state_nxt = ST_FIN;
      ST_WR_SETTLE:  w_state_nxt = w_last ? ST_FIN : ST_WR_FETCH;
      ST_FIN:        w_state_nxt = ST_IDLE;
      default:       w_state_nxt = ST_IDLE;
    endcase
  end

  // Wait counter restarts on every state change and saturates while parked
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state <= ST_IDLE;
      r_wait  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state) r_wait <= '0;
      else if (r_wait != '1)      r_wait <= r_wait + 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_remain   <= '0;
      r_obj      <= '0;
      r_word     <= '0;
      r_err      <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_data  <= '0;
      r_wdata    <= '0;
      r_waddr    <= '0;
      r_raddr    <= '0;
      r_wen      <= 1'b0;
      r_ren      <= 1'b0;
    end else begin
      r_ren <= w_rd_issue;
      r_wen <= w_wr_issue;
      if (w_accept) begin
        r_obj    <= cmd_obj;
        r_word   <= cmd_word;
        r_remain <= cmd_lines;
        r_err    <= 1'b0;
      end
      if (w_abort)    r_err   <= 1'b1;
      if (w_rd_issue) r_raddr <= mk_addr(r_obj, r_word);
      if (w_wr_issue) r_waddr <= mk_addr(r_obj, r_word);
      if (w_wr_take)  r_wdata <= wr_data;
      if (w_rd_cap) begin
        r_rd_data  <= bus.APB_RDATA;
        r_rd_valid <= 1'b1;
        r_rd_last  <= w_last;
      end else if (w_rd_take) begin
        r_rd_valid <= 1'b0;
        r_rd_last  <= 1'b0;
      end
      if (w_step) begin
        r_remain <= r_remain - 1'b1;
        r_word   <= r_word + WORD_W'(LINE_WORDS);
      end
    end
  end

  assign cmd_ready       = (r_state == ST_IDLE);
  assign wr_ready        = (r_state == ST_WR_FETCH);
  assign done            = (r_state == ST_FIN);
  assign err             = r_err;
  assign rd_valid        = r_rd_valid;
  assign rd_last         = r_rd_last;
  assign rd_data         = r_rd_data;
  assign bus.APB_WADDR   = r_waddr;
  assign bus.APB_RADDR   = r_raddr;
  assign bus.APB_WDATA   = r_wdata;
  assign bus.APB_WENABLE = r_wen;
  assign bus.APB_RENABLE = r_ren;

endmodule
`default_nettype wire

// File: tb/tb_line_dma_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_line_dma_master : directed bench with a behavioural line-memory slave  |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_line_dma_master;

  logic         ACLK = 1'b0;
  logic         ARESETN = 1'b0;
  logic         cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [2:0]   cmd_obj = '0;
  logic [9:0]   cmd_word = '0;
  logic [6:0]   cmd_lines = '0;
  logic         cmd_ready, rd_valid, rd_last, wr_ready, done, err;
  logic         rd_ready = 1'b0, wr_valid = 1'b0;
  logic [511:0] rd_data;
  logic [511:0] wr_data = '0;

  int checks = 0;
  int errors = 0;

  line_dma_master_if bus ();

  line_dma_master dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_obj(cmd_obj), .cmd_word(cmd_word), .cmd_lines(cmd_lines),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .done(done), .err(err), .bus(bus)
  );

  always #5 ACLK = ~ACLK;

  logic [31:0]  mem [3][1024];
  logic [511:0] beat_q[$];
  bit           last_q[$];
  logic [39:0]  raddr_q[$];
  logic [39:0]  waddr_q[$];
  int  ren_cnt = 0, wen_cnt = 0, done_cnt = 0, viol = 0;
  int  rd_cnt = -1, wr_cnt = -1, wr_lat = 3;
  bit  slave_dead = 0;

  function automatic int oidx(input logic [2:0] o);
    return (o == 3'd4) ? 0 : (o == 3'd2) ? 1 : 2;
  endfunction

  function automatic logic [31:0] pat(input int oi, input int w);
    return 32'hA000_0000 | (oi << 16) | w;
  endfunction

  function automatic logic [511:0] exp_line(input int oi, input int w);
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[k*32 +: 32] = pat(oi, (w + k) & 1023);
    return l;
  endfunction

  // Memory slave: idle while READY=1, ~18-cycle reads, programmable-latency writes
  initial begin
    for (int o = 0; o < 3; o++)
      for (int w = 0; w < 1024; w++) mem[o][w] = pat(o, w);
    bus.APB_RREADY = 1'b1; bus.APB_WREADY = 1'b1;
    bus.APB_RVALID = 1'b0; bus.APB_RDATA = '0;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        rd_cnt = -1; wr_cnt = -1;
        bus.APB_RREADY = 1'b1; bus.APB_WREADY = 1'b1; bus.APB_RVALID = 1'b0;
      end else begin
        bus.APB_RVALID = 1'b0;
        if (rd_cnt == 0) begin
          logic [39:0] a;
          a = bus.APB_RADDR;
          raddr_q.push_back(a);
          for (int k = 0; k < 16; k++)
            bus.APB_RDATA[k*32 +: 32] = mem[oidx(a[39:37])][(int'(a[11:2]) + k) & 1023];
          bus.APB_RVALID = 1'b1; bus.APB_RREADY = 1'b1; rd_cnt = -1;
        end else if (rd_cnt > 0) rd_cnt--;
        if (wr_cnt == 0) begin
          logic [39:0] a;
          a = bus.APB_WADDR;
          for (int k = 0; k < 16; k++)
            mem[oidx(a[39:37])][(int'(a[11:2]) + k) & 1023] = bus.APB_WDATA[k*32 +: 32];
          bus.APB_WREADY = 1'b1; wr_cnt = -1;
        end else if (wr_cnt > 0) wr_cnt--;
        if (bus.APB_RENABLE) begin
          ren_cnt++;
          if (!bus.APB_RREADY) viol++;
          if (!slave_dead) begin bus.APB_RREADY = 1'b0; rd_cnt = 18; end
        end
        if (bus.APB_WENABLE) begin
          wen_cnt++;
          waddr_q.push_back(bus.APB_WADDR);
          if (!bus.APB_WREADY) viol++;
          bus.APB_WREADY = 1'b0; wr_cnt = wr_lat;
        end
      end
    end
  end

  always @(negedge ACLK) begin
    if (ARESETN) begin
      if (rd_valid && rd_ready) begin beat_q.push_back(rd_data); last_q.push_back(rd_last); end
      if (done) done_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_cmd(input bit w, input logic [2:0] o, input logic [9:0] wd,
                          input logic [6:0] n);
    @(posedge ACLK); #1;
    cmd_valid = 1'b1; cmd_write = w; cmd_obj = o; cmd_word = wd; cmd_lines = n;
    for (int i = 0; i < 50; i++) begin @(negedge ACLK); if (cmd_ready) break; end
    @(posedge ACLK); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (cyc < 2000) begin
      @(negedge ACLK); cyc++;
      if (done) break;
    end
    checks++;
    if (!done) begin errors++; $display("FAIL done_timeout: done=%0b after %0d cycles, required 1", done, cyc); end
  endtask

  task automatic clear_q();
    beat_q.delete(); last_q.delete(); raddr_q.delete(); waddr_q.delete();
  endtask

  task automatic test_reset();
    ARESETN = 1'b0;
    repeat (3) @(negedge ACLK);
    checks++;
    if ({cmd_ready, rd_valid, wr_ready, done, err, bus.APB_RENABLE, bus.APB_WENABLE} !== 7'b1000000) begin
      errors++; $display("FAIL reset_ctrl: got %b required 1000000",
        {cmd_ready, rd_valid, wr_ready, done, err, bus.APB_RENABLE, bus.APB_WENABLE});
    end
    checks++;
    if ({bus.APB_RADDR, bus.APB_WADDR} !== 80'h0 || bus.APB_WDATA !== '0) begin
      errors++; $display("FAIL reset_bus: raddr=%h waddr=%h wdata nonzero=%0b required 0",
        bus.APB_RADDR, bus.APB_WADDR, bus.APB_WDATA !== '0);
    end
    @(posedge ACLK); #1 ARESETN = 1'b1;
  endtask

  task automatic test_read_basic();
    int cyc, d0;
    clear_q(); rd_ready = 1'b1; d0 = done_cnt;
    send_cmd(0, 3'd4, 10'd0, 7'd2);
    wait_done(cyc);
    repeat (3) @(negedge ACLK);
    checks++;
    if (beat_q.size() != 2) begin errors++; $display("FAIL rd_beats: got %0d required 2", beat_q.size()); end
    else begin
      checks++;
      if (beat_q[0] !== exp_line(0, 0)) begin errors++; $display("FAIL rd_line0: got %h required %h", beat_q[0][63:0], exp_line(0, 0)); end
      checks++;
      if (beat_q[1] !== exp_line(0, 16)) begin errors++; $display("FAIL rd_line1: got %h required %h", beat_q[1][63:0], exp_line(0, 16)); end
      checks++;
      if (last_q[0] !== 1'b0 || last_q[1] !== 1'b1) begin errors++; $display("FAIL rd_last: got %b%b required 01", last_q[0], last_q[1]); end
    end
    checks++;
    if (done_cnt - d0 != 1 || err !== 1'b0) begin errors++; $display("FAIL rd_done_err: done pulses %0d err %b required 1/0", done_cnt - d0, err); end
  endtask

  task automatic test_write_readback();
    int cyc, w0;
    logic [511:0] wl;
    for (int k = 0; k < 16; k++) wl[k*32 +: 32] = k;
    clear_q(); w0 = wen_cnt;
    wr_data = wl; wr_valid = 1'b1;
    send_cmd(1, 3'd2, 10'd32, 7'd1);
    wait_done(cyc);
    #1 wr_valid = 1'b0;
    repeat (3) @(negedge ACLK);
    checks++;
    if (wen_cnt - w0 != 1) begin errors++; $display("FAIL wr_pulses: got %0d required 1", wen_cnt - w0); end
    checks++;
    if (waddr_q.size() < 1 || waddr_q[0] !== 40'h40_0000_0080) begin
      errors++; $display("FAIL wr_addr: got %h required 4000000080", waddr_q.size() ? waddr_q[0] : 40'h0);
    end
    clear_q(); rd_ready = 1'b1;
    send_cmd(0, 3'd2, 10'd32, 7'd1);
    wait_done(cyc);
    repeat (2) @(negedge ACLK);
    checks++;
    if (beat_q.size() != 1 || beat_q[0] !== wl) begin
      errors++; $display("FAIL wr_readback: beats %0d data %h required %h", beat_q.size(), beat_q.size() ? beat_q[0][95:0] : 96'h0, wl[95:0]);
    end
  endtask

  task automatic test_backpressure();
    int cyc, r0;
    bit stable;
    logic [511:0] hold;
    clear_q(); rd_ready = 1'b0;
    send_cmd(0, 3'd1, 10'd64, 7'd3);
    for (int i = 0; i < 200; i++) begin @(negedge ACLK); if (rd_valid) break; end
    hold = rd_data; r0 = ren_cnt; stable = rd_valid;
    repeat (50) begin
      @(negedge ACLK);
      if (!rd_valid || rd_data !== hold) stable = 0;
    end
    checks++;
    if (!stable || hold !== exp_line(2, 64)) begin errors++; $display("FAIL bp_hold: stable=%0b data %h required %h", stable, hold[63:0], exp_line(2, 64)); end
    checks++;
    if (ren_cnt != r0) begin errors++; $display("FAIL bp_no_issue: renable pulses %0d required 0", ren_cnt - r0); end
    @(posedge ACLK); #1 rd_ready = 1'b1;
    wait_done(cyc);
    repeat (2) @(negedge ACLK);
    checks++;
    if (beat_q.size() != 3) begin errors++; $display("FAIL bp_beats: got %0d required 3", beat_q.size()); end
    else begin
      checks++;
      if (beat_q[1] !== exp_line(2, 80) || beat_q[2] !== exp_line(2, 96) || last_q[2] !== 1'b1 || last_q[0] !== 1'b0) begin
        errors++; $display("FAIL bp_order: got %h/%h last %b required %h/%h last 1",
          beat_q[1][31:0], beat_q[2][31:0], last_q[2], exp_line(2, 80), exp_line(2, 96));
      end
    end
  endtask

  task automatic test_wrap();
    int cyc;
    logic [39:0] a0, a1;
    clear_q(); rd_ready = 1'b1;
    send_cmd(0, 3'd4, 10'd1008, 7'd2);
    wait_done(cyc);
    repeat (2) @(negedge ACLK);
    checks++;
    if (raddr_q.size() != 2) begin errors++; $display("FAIL wrap_count: got %0d required 2", raddr_q.size()); end
    else begin
      a0 = raddr_q[0]; a1 = raddr_q[1];
      checks++;
      if (a0 !== 40'h80_0000_0FC0 || a1 !== 40'h80_0000_0000) begin
        errors++; $display("FAIL wrap_addr: got %h %h required 8000000fc0 8000000000", a0, a1);
      end
    end
    checks++;
    if (beat_q.size() != 2 || beat_q[1] !== exp_line(0, 0)) begin
      errors++; $display("FAIL wrap_data: beats %0d required 2 with line at word 0", beat_q.size());
    end
  endtask

  task automatic test_timeout();
    int cyc;
    slave_dead = 1'b1; rd_ready = 1'b1; clear_q();
    send_cmd(0, 3'd4, 10'd0, 7'd2);
    wait_done(cyc);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL tmo_err: got %b required 1", err); end
    checks++;
    if (cyc < 250 || cyc > 265) begin errors++; $display("FAIL tmo_latency: got %0d cycles required 250..265", cyc); end
    slave_dead = 1'b0;
    repeat (2) @(negedge ACLK);
    send_cmd(0, 3'd4, 10'd0, 7'd1);
    @(negedge ACLK);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL tmo_clear: got %b required 0", err); end
    wait_done(cyc);
    repeat (2) @(negedge ACLK);
    checks++;
    if (beat_q.size() != 1 || beat_q[0] !== exp_line(0, 0)) begin
      errors++; $display("FAIL tmo_recover: beats %0d required 1 with line at word 0", beat_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int cyc, r0, w0, d0;
    wr_lat = 10; wr_data = {16{32'h5A5A_0000}}; wr_valid = 1'b1;
    send_cmd(1, 3'd1, 10'd128, 7'd2);
    for (int i = 0; i < 100; i++) begin @(negedge ACLK); if (bus.APB_WENABLE) break; end
    repeat (3) @(negedge ACLK);
    #2 ARESETN = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, rd_valid, wr_ready, done, err, bus.APB_RENABLE, bus.APB_WENABLE} !== 7'b1000000) begin
      errors++; $display("FAIL mid_reset_ctrl: got %b required 1000000",
        {cmd_ready, rd_valid, wr_ready, done, err, bus.APB_RENABLE, bus.APB_WENABLE});
    end
    checks++;
    if ({bus.APB_RADDR, bus.APB_WADDR} !== 80'h0 || bus.APB_WDATA !== '0) begin
      errors++; $display("FAIL mid_reset_bus: waddr=%h wdata nonzero=%0b required 0", bus.APB_WADDR, bus.APB_WDATA !== '0);
    end
    wr_valid = 1'b0; wr_lat = 3;
    repeat (2) @(negedge ACLK);
    @(posedge ACLK); #1 ARESETN = 1'b1;
    clear_q(); rd_ready = 1'b1;
    send_cmd(0, 3'd1, 10'd128, 7'd1);
    wait_done(cyc);
    repeat (2) @(negedge ACLK);
    checks++;
    if (beat_q.size() != 1 || beat_q[0] !== exp_line(2, 128)) begin
      errors++; $display("FAIL post_reset_read: beats %0d data %h required %h", beat_q.size(), beat_q.size() ? beat_q[0][31:0] : 32'h0, exp_line(2, 128));
    end
    r0 = ren_cnt; w0 = wen_cnt; d0 = done_cnt;
    send_cmd(0, 3'd4, 10'd0, 7'd0);
    @(negedge ACLK);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL zero_lines_done: got %b required 1", done); end
    repeat (5) @(negedge ACLK);
    checks++;
    if (ren_cnt != r0 || wen_cnt != w0 || done_cnt - d0 != 1) begin
      errors++; $display("FAIL zero_lines_bus: ren %0d wen %0d done %0d required 0 0 1", ren_cnt - r0, wen_cnt - w0, done_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_readback();
    test_backpressure();
    test_wrap();
    test_timeout();
    test_reset_mid();
    checks++;
    if (viol != 0) begin errors++; $display("FAIL bus_protocol: enable while not ready %0d times, required 0", viol); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
